usb_crc_serializer: RTL and testbench
=====================================

Name: usb_crc_serializer

Overview:
- Parametrised successor to the token CRC5 encoder; serializes a variable-length USB packet field LSB-first, then appends the matching CRC.
- Supports CRC5 (token fields) and CRC16 (data payloads).
- Sits between the packet assembler (parallel load) and the bit-stuffing/NRZI stage (serial, ready/valid handshake).
- Replaces fixed-length PISO + counter pairs with a single FSM-driven datapath.

Parameters:
- MAX_BITS, 64, maximum payload bits per transfer (≥ 11).
- LEN_W, $clog2(MAX_BITS+1), width of the length field.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset; asynchronous, active-low
- start  in  1  load request; accepted only when ready_in = 1
- crc16  in  1  mode: 0 = CRC5, 1 = CRC16; sampled with start
- payload  in  MAX_BITS  field bits; payload[0] is transmitted first
- len  in  LEN_W  payload bit count, 0..MAX_BITS; sampled with start
- ready_in  out  1  block is idle and can accept start
- bit_out  out  1  current serial bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  downstream accepts the bit this cycle
- last  out  1  bit_out is the final CRC bit of the transfer

Behaviour:
- Reset values: ready_in = 1, bit_valid = 0, bit_out = 0, last = 0; FSM in IDLE; CRC register all ones.
- Transfer: a bit transfers on any cycle with bit_valid && bit_ready.
- Handshake stability: while bit_valid = 1 and bit_ready = 0, bit_out, last and all internal state hold unchanged.
- FSM states: IDLE, DATA, CRC.
- IDLE:
  - ready_in = 1.
  - On start: capture payload, len (values > MAX_BITS clamp to MAX_BITS), and crc16.
  - CRC register presets to all ones (5 or 16 bits active). Bit counter cleared.
  - Next state is DATA if len > 0, else CRC.
- Latency: first bit_valid appears the cycle after start is accepted. No bubbles between bits while bit_ready stays high.
- DATA:
  - bit_out = captured payload[cnt].
  - On transfer, the CRC LFSR advances with that bit:
    - fb = bit ^ reg[msb]; reg = (reg << 1) ^ (fb ? POLY : 0)
    - POLY = 5'h05 for CRC5, 16'h8005 for CRC16.
  - cnt increments. After the transfer of bit len-1, go to CRC with cnt = 0.
- CRC:
  - Emit the complemented remainder, most-significant bit first: bit_out = ~reg[W-1-cnt], W = 5 or 16.
  - The CRC register is frozen in this state.
  - last = 1 when cnt = W-1.
  - Transfer with last = 1 returns to IDLE; ready_in rises the next cycle.
- start while busy: ignored. No queuing; payload, len and crc16 are not resampled.
- Reset mid-transfer: immediate abort to reset values. No partial CRC is emitted.
- ready_in and bit_valid are never both 1.

Decomposition:
- Package usb_crc_pkg:
  - CRC5_POLY, CRC16_POLY, CRC5_W, CRC16_W.
  - Enum ser_state_t {IDLE, DATA, CRC}.
  - Enum crc_mode_t.
- Sub-module usb_crc_lfsr:
  - 16-bit register with mode select.
  - Ports: clk, rst_b, preset, advance, din, crc16, rem[15:0].
  - In CRC5 mode only the low 5 bits are active.
- Top level holds the FSM, bit counter, payload capture register and output mux.

Test Plan:
- CRC5, len = 11, payload = 0 (addr 0, endp 0), bit_ready tied high -> 11 zeros then CRC bits 0,1,0,0,0; last on the 16th bit; ready_in back at 1 on the following cycle.
- CRC16, len = 0 -> first bit_valid one cycle after start; 16 zero bits (zero-length DATA CRC 0x0000); last on bit 16.
- CRC16, len = 8, payload = 8'h00, random bit_ready stalls -> serial stream identical to the no-stall run; outputs stable during every stall; total transfers = 24.
- start pulsed during DATA with different payload/len/crc16 -> ignored; stream matches the first request exactly.
- rst_b asserted mid-CRC phase -> bit_valid = 0 and ready_in = 1 immediately; next CRC5 len = 11 zero transfer again yields 0,1,0,0,0.
- Reference-model sweep, 500 random packets: len 0..MAX_BITS in both modes, plus len = MAX_BITS+5 (must clamp to MAX_BITS); compare against a software CRC5/CRC16 model.

Source files
------------

// File: rtl/usb_crc_pkg.sv
// Shared constants and types for the USB CRC serializer slice.
package usb_crc_pkg;

    localparam int unsigned CRC5_W  = 5;
    localparam int unsigned CRC16_W = 16;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CRC
    } ser_state_t;

    typedef enum logic {
        MODE_CRC5,
        MODE_CRC16
    } crc_mode_t;

endpackage

// File: rtl/usb_crc_lfsr.sv
// Dual-mode CRC LFSR; in CRC5 mode only rem[4:0] is active.
module usb_crc_lfsr
    import usb_crc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        preset,
    input  logic        advance,
    input  logic        din,
    input  logic        crc16,
    output logic [15:0] rem
);

    logic fb5;
    logic fb16;

    assign fb5  = din ^ rem[CRC5_W-1];
    assign fb16 = din ^ rem[CRC16_W-1];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rem <= '1;
        end else if (preset) begin
            rem <= '1;
        end else if (advance) begin
            if (crc16) begin
                rem <= {rem[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : '0);
            end else begin
                rem[4:0] <= {rem[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : '0);
            end
        end
    end

endmodule

// File: rtl/usb_crc_serializer.sv
// Serializes a captured payload LSB-first, then the complemented CRC5/CRC16 MSB-first.
module usb_crc_serializer
    import usb_crc_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic                crc16,
    input  logic [MAX_BITS-1:0] payload,
    input  logic [LEN_W-1:0]    len,
    output logic                ready_in,
    output logic                bit_out,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic                last
);

    ser_state_t          state;
    ser_state_t          state_nxt;
    logic [MAX_BITS-1:0] pay_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt;
    crc_mode_t           mode_q;
    logic [15:0]         rem;
    logic [LEN_W-1:0]    len_clamped;
    logic [3:0]          crc_top;
    logic [3:0]          crc_idx;
    logic                pay_bit;
    logic                xfer;
    logic                accept;
    logic                data_done;

    assign ready_in    = (state == IDLE);
    assign bit_valid   = (state != IDLE);
    assign xfer        = bit_valid & bit_ready;
    assign accept      = ready_in & start;
    assign len_clamped = (len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len;
    assign crc_top     = (mode_q == MODE_CRC16) ? 4'(CRC16_W - 1) : 4'(CRC5_W - 1);
    assign crc_idx     = crc_top - cnt[3:0];
    assign data_done   = (cnt == LEN_W'(len_q - 1'b1));
    assign last        = (state == CRC) && (cnt == LEN_W'(crc_top));

    // Explicit compare mux keeps the counter width independent of MAX_BITS index width.
    always_comb begin
        pay_bit = 1'b0;
        for (int unsigned i = 0; i < MAX_BITS; i++) begin
            if (cnt == LEN_W'(i)) begin
                pay_bit = pay_q[i];
            end
        end
    end

    always_comb begin
        bit_out = 1'b0;
        case (state)
            DATA:    bit_out = pay_bit;
            CRC:     bit_out = ~rem[crc_idx];
            default: bit_out = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (len_clamped != '0) ? DATA : CRC;
            DATA: if (xfer && data_done) state_nxt = CRC;
            CRC:  if (xfer && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pay_q  <= '0;
            len_q  <= '0;
            cnt    <= '0;
            mode_q <= MODE_CRC5;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pay_q  <= payload;
                        len_q  <= len_clamped;
                        mode_q <= crc16 ? MODE_CRC16 : MODE_CRC5;
                        cnt    <= '0;
                    end
                end
                DATA: if (xfer) cnt <= data_done ? '0 : cnt + 1'b1;
                CRC:  if (xfer) cnt <= last ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    usb_crc_lfsr u_lfsr (
        .clk     (clk),
        .rst_b   (rst_b),
        .preset  (accept),
        .advance ((state == DATA) && xfer),
        .din     (bit_out),
        .crc16   (mode_q == MODE_CRC16),
        .rem     (rem)
    );

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Randomized bench for usb_crc_serializer against a software CRC stream model.
module tb_usb_crc_serializer;

    localparam int MAX_BITS = 64;
    localparam int LEN_W    = $clog2(MAX_BITS + 1);

    logic                clk = 1'b0;
    logic                rst_b;
    logic                start;
    logic                crc16;
    logic [MAX_BITS-1:0] payload;
    logic [LEN_W-1:0]    len;
    logic                ready_in;
    logic                bit_out;
    logic                bit_valid;
    logic                bit_ready;
    logic                last;

    int n_tests = 0;
    int n_fail  = 0;

    bit got_q[$];
    bit exp_q[$];
    int got_last_idx;
    bit timed_out;
    int unstable;
    int excl;

    always #5 clk = ~clk;

    usb_crc_serializer #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .crc16     (crc16),
        .payload   (payload),
        .len       (len),
        .ready_in  (ready_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .last      (last)
    );

    // Expected serial stream: payload bits LSB-first, then ~CRC MSB-first.
    task automatic build_expected(input bit m16, input logic [MAX_BITS-1:0] p, input int n);
        int w;
        int poly;
        int mask;
        int crc;
        int b;
        int fb;
        w    = m16 ? 16 : 5;
        poly = m16 ? 'h8005 : 'h05;
        mask = (1 << w) - 1;
        crc  = mask;
        if (n > MAX_BITS) n = MAX_BITS;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b  = int'(p[i]);
            fb = b ^ ((crc >> (w - 1)) & 1);
            crc = ((crc << 1) & mask) ^ (fb != 0 ? poly : 0);
            exp_q.push_back(bit'(b));
        end
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(bit'(((crc >> (w - 1 - i)) & 1) ^ 1));
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] != exp_q[i]) return i;
        end
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Called on a negedge; returns on the negedge one cycle after start was sampled.
    task automatic do_start(input bit m16, input logic [MAX_BITS-1:0] p, input int n);
        start   = 1'b1;
        crc16   = m16;
        payload = p;
        len     = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int stall_pct, input bit poke);
        int cyc;
        bit done;
        bit held;
        bit held_bit;
        bit held_last;
        got_q.delete();
        got_last_idx = -1;
        unstable = 0;
        excl = 0;
        done = 0;
        held = 0;
        held_bit = 0;
        held_last = 0;
        cyc = 0;
        while (!done && cyc < 400) begin
            if (ready_in && bit_valid) excl++;
            if (held && (!bit_valid || bit_out !== held_bit || last !== held_last)) unstable++;
            if (poke) begin
                if (cyc == 3) begin
                    start   = 1'b1;
                    crc16   = ~crc16;
                    payload = {$urandom, $urandom};
                    len     = LEN_W'(5);
                end else begin
                    start = 1'b0;
                end
            end
            bit_ready = (int'($urandom_range(99)) >= stall_pct);
            held = 0;
            if (bit_valid) begin
                if (bit_ready) begin
                    got_q.push_back(bit_out);
                    if (last) begin
                        got_last_idx = got_q.size() - 1;
                        done = 1;
                    end
                end else begin
                    held = 1;
                    held_bit = bit_out;
                    held_last = last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        timed_out = !done;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        start = 1'b0;
        crc16 = 1'b0;
        payload = '0;
        len = '0;
        bit_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({ready_in, bit_valid, bit_out, last} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_values got ready/valid/out/last=%b required 1000",
                     {ready_in, bit_valid, bit_out, last});
        end
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_crc5_token_zero();
        logic [4:0] k;
        int d;
        k = 5'b01000;
        exp_q.delete();
        for (int i = 0; i < 11; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 5; i++) exp_q.push_back(k[4 - i]);
        do_start(1'b0, '0, 11);
        collect(0, 1'b0);
        d = first_diff();
        n_tests++;
        if (timed_out || d >= 0) begin
            n_fail++;
            $display("FAIL crc5_zero_stream got len=%0d diff_at=%0d timeout=%0b required len=16",
                     got_q.size(), d, timed_out);
        end
        n_tests++;
        if (got_last_idx != 15) begin
            n_fail++;
            $display("FAIL crc5_zero_last got idx=%0d required 15", got_last_idx);
        end
        n_tests++;
        if (ready_in !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL crc5_zero_idle got ready_in=%b bit_valid=%b required 1/0", ready_in, bit_valid);
        end
    endtask

    task automatic test_crc16_len0();
        int d;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        bit_ready = 1'b1;
        do_start(1'b1, {$urandom, $urandom}, 0);
        n_tests++;
        if (bit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL crc16_len0_latency got bit_valid=%b required 1", bit_valid);
        end
        collect(0, 1'b0);
        d = first_diff();
        n_tests++;
        if (timed_out || d >= 0 || got_last_idx != 15) begin
            n_fail++;
            $display("FAIL crc16_len0_stream got len=%0d diff_at=%0d last_idx=%0d required 16 zeros last_idx=15",
                     got_q.size(), d, got_last_idx);
        end
    endtask

    task automatic test_stall();
        int d;
        build_expected(1'b1, '0, 8);
        do_start(1'b1, '0, 8);
        collect(50, 1'b0);
        d = first_diff();
        n_tests++;
        if (timed_out || d >= 0 || got_q.size() != 24) begin
            n_fail++;
            $display("FAIL stall_stream got transfers=%0d diff_at=%0d required 24 matching", got_q.size(), d);
        end
        n_tests++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL stall_stability got %0d changes during stalls required 0", unstable);
        end
    endtask

    task automatic test_start_busy();
        logic [MAX_BITS-1:0] p;
        int d;
        p = {$urandom, $urandom};
        build_expected(1'b0, p, 20);
        do_start(1'b0, p, 20);
        collect(10, 1'b1);
        d = first_diff();
        n_tests++;
        if (timed_out || d >= 0) begin
            n_fail++;
            $display("FAIL start_busy_stream got len=%0d diff_at=%0d required len=%0d",
                     got_q.size(), d, exp_q.size());
        end
        @(negedge clk);
        n_tests++;
        if (ready_in !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_queued got ready_in=%b bit_valid=%b required 1/0", ready_in, bit_valid);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        bit_ready = 1'b1;
        do_start(1'b0, {$urandom, $urandom}, 11);
        repeat (13) @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_tests++;
        if (bit_valid !== 1'b0 || ready_in !== 1'b1 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got bit_valid=%b ready_in=%b last=%b required 0/1/0",
                     bit_valid, ready_in, last);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        build_expected(1'b0, '0, 11);
        do_start(1'b0, '0, 11);
        collect(0, 1'b0);
        d = first_diff();
        n_tests++;
        if (timed_out || d >= 0 || got_q[11] != 1'b0 || got_q[12] != 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_rerun got len=%0d diff_at=%0d required crc 0,1,0,0,0", got_q.size(), d);
        end
    endtask

    task automatic test_sweep();
        bit m16;
        int n;
        int d;
        logic [MAX_BITS-1:0] p;
        int bad;
        int bad_last;
        int bad_hs;
        bad = 0;
        bad_last = 0;
        bad_hs = 0;
        for (int k = 0; k < 500; k++) begin
            m16 = bit'($urandom_range(1));
            n = (k % 25 == 0) ? MAX_BITS + 5 : int'($urandom_range(MAX_BITS));
            p = {$urandom, $urandom};
            build_expected(m16, p, n);
            do_start(m16, p, n);
            collect(int'($urandom_range(20)), 1'b0);
            d = first_diff();
            if (timed_out || d >= 0) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL sweep_stream pkt=%0d mode16=%0b len=%0d got len=%0d diff_at=%0d required len=%0d",
                             k, m16, n, got_q.size(), d, exp_q.size());
            end
            if (got_last_idx != exp_q.size() - 1) bad_last++;
            if (unstable != 0 || excl != 0) bad_hs++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sweep_streams got %0d bad packets required 0", bad);
        end
        n_tests++;
        if (bad_last != 0) begin
            n_fail++;
            $display("FAIL sweep_last got %0d misplaced last required 0", bad_last);
        end
        n_tests++;
        if (bad_hs != 0) begin
            n_fail++;
            $display("FAIL sweep_handshake got %0d violations required 0", bad_hs);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_crc5_token_zero();
        test_crc16_len0();
        test_stall();
        test_start_busy();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
